// File: rtl/dispatch_decoder_if.sv
// Fetch-side and unit-side signal bundle for dispatch_decoder.
// in_valid/in_ready: a word transfers on a rising edge where both are high; in_ready never looks at in_valid.
interface dispatch_decoder_if #(
    parameter int IW = 16
);
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_instr;
    logic          start_move;
    logic          start_movi;
    logic          start_ALU;
    logic          start_ALUI;
    logic [IW-1:0] op_instr;
    logic          done;

    modport master (
        output in_valid, in_instr, done,
        input  in_ready, start_move, start_movi, start_ALU, start_ALUI, op_instr
    );

    modport slave (
        input  in_valid, in_instr, done,
        output in_ready, start_move, start_movi, start_ALU, start_ALUI, op_instr
    );
endinterface

// File: rtl/dispatch_decoder.sv
// Queued instruction dispatcher: FIFO of instruction words, opcode classification of the head,
// registered start pulse per execution unit, and a done/timeout wait per issued instruction.
module dispatch_decoder #(
    parameter int IW      = 16,
    parameter int OPW     = 4,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    dispatch_decoder_if.slave        bus,
    output logic                     busy,
    output logic                     illegal,
    output logic                     timeout,
    output logic [$clog2(DEPTH):0]   count,
    output logic [1:0]               dbg_state
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    localparam logic [OPW-1:0] OP_ALL_ONES = '1;
    localparam logic [15:0]    TIMER_LAST  = 16'(TIMEOUT - 1);
    localparam logic [CW-1:0]  FULL_COUNT  = CW'(DEPTH);

    // Class encoding: {move, movi, ALU, ALUI}; all-zero means illegal.
    function automatic logic [3:0] decode_class(input logic [OPW-1:0] op);
        logic [3:0] cls;
        cls = 4'b0000;
        if (op <= OPW'(6))           cls = 4'b0010;
        else if (op == OPW'(7))      cls = 4'b1000;
        else if (op == OPW'(8) || op == OPW'(9)) cls = 4'b0001;
        else if (op == OP_ALL_ONES)  cls = 4'b0100;
        return cls;
    endfunction

    logic [IW-1:0]  mem_q [DEPTH];
    logic [IW-1:0]  mem_d [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [1:0]     state_q, state_d;
    logic [15:0]    timer_q, timer_d;
    logic [IW-1:0]  op_instr_q, op_instr_d;
    logic [3:0]     start_q, start_d;
    logic           illegal_q, illegal_d;
    logic           timeout_q, timeout_d;

    logic [IW-1:0]  head;
    logic [3:0]     head_class;
    logic           in_ready_int;
    logic           push;
    logic           pop;

    assign head         = mem_q[rd_ptr_q];
    assign head_class   = decode_class(head[IW-1 -: OPW]);
    // Full refuses input even on a popping cycle, keeping in_ready a pure function of state.
    assign in_ready_int = (count_q != FULL_COUNT);
    assign push         = bus.in_valid && in_ready_int;
    assign pop          = (state_q == S_IDLE) && enable && (count_q != '0);

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        state_d    = state_q;
        timer_d    = timer_q;
        op_instr_d = op_instr_q;
        start_d    = 4'b0000;
        illegal_d  = 1'b0;
        timeout_d  = 1'b0;

        if (push) begin
            mem_d[wr_ptr_q] = bus.in_instr;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    rd_ptr_d = rd_ptr_q + AW'(1);
                    if (head_class != 4'b0000) begin
                        op_instr_d = head;
                        state_d    = S_ISSUE;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                start_d = decode_class(op_instr_q[IW-1 -: OPW]);
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.done) begin
                    state_d = S_IDLE;
                end else if (timer_q == TIMER_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= S_IDLE;
            timer_q    <= '0;
            op_instr_q <= '0;
            start_q    <= 4'b0000;
            illegal_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            timer_q    <= timer_d;
            op_instr_q <= op_instr_d;
            start_q    <= start_d;
            illegal_q  <= illegal_d;
            timeout_q  <= timeout_d;
        end
    end

    // Storage needs no reset: occupancy and pointers decide what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.in_ready   = in_ready_int;
    assign bus.start_move = start_q[3];
    assign bus.start_movi = start_q[2];
    assign bus.start_ALU  = start_q[1];
    assign bus.start_ALUI = start_q[0];
    assign bus.op_instr   = op_instr_q;
    assign busy           = (state_q != S_IDLE) || (count_q != '0);
    assign illegal        = illegal_q;
    assign timeout        = timeout_q;
    assign count          = count_q;
    assign dbg_state      = state_q;
endmodule

// File: tb/tb_dispatch_decoder.sv
// Bench for dispatch_decoder: opcode table plus hand-written sequences for queueing, timeout and reset.
module tb_dispatch_decoder;
  localparam logic [3:0] K_MOVE = 4'b1000;
  localparam logic [3:0] K_MOVI = 4'b0100;
  localparam logic [3:0] K_ALU  = 4'b0010;
  localparam logic [3:0] K_ALUI = 4'b0001;
  localparam logic [3:0] K_ILL  = 4'b0000;

  typedef struct {
    logic [15:0] instr;
    logic [3:0]  kind;
    int          delay;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       busy;
  logic       illegal;
  logic       timeout;
  logic [2:0] count;
  logic [1:0] dbg_state;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int last_start_cyc = -1;
  int illegal_cnt = 0;
  int timeout_cnt = 0;
  logic [19:0] exp_q[$];
  vec_t vecs[9];

  dispatch_decoder_if #(.IW(16)) bus ();

  dispatch_decoder #(.IW(16), .OPW(4), .DEPTH(4), .TIMEOUT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .bus       (bus.slave),
    .busy      (busy),
    .illegal   (illegal),
    .timeout   (timeout),
    .count     (count),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.done = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // driver tasks
  task automatic push(input logic [15:0] instr);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    check("push_ready_in_time", 32'(n < 20), 32'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic push_exp(input logic [15:0] instr, input logic [3:0] kind);
    exp_q.push_back((kind == K_ILL) ? 20'h0 : {kind, instr});
    push(instr);
  endtask

  task automatic wait_start();
    int n;
    n = 0;
    while (!(bus.start_move || bus.start_movi || bus.start_ALU || bus.start_ALUI) && n < 20) begin
      tick();
      n++;
    end
    check("start_in_time", 32'(n < 20), 32'd1);
  endtask

  task automatic serve(input int n_starts, input int delay);
    for (int i = 0; i < n_starts; i++) begin
      wait_start();
      repeat (delay) tick();
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
    end
  endtask

  // scoreboard
  task automatic sb_event(input logic [19:0] ev);
    logic [19:0] exp;
    if (exp_q.size() == 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL sb_unexpected: got %0h, required no event", ev);
    end else begin
      exp = exp_q.pop_front();
      check("sb_event", 32'(ev), 32'(exp));
    end
  endtask

  always @(negedge clk) begin
    logic [3:0] s;
    s = {bus.start_move, bus.start_movi, bus.start_ALU, bus.start_ALUI};
    if (s != 4'b0000) begin
      check("start_onehot", 32'($countones(s)), 32'd1);
      if (last_start_cyc >= 0) check("start_spacing", 32'((cyc - last_start_cyc) >= 3), 32'd1);
      last_start_cyc = cyc;
      sb_event({s, bus.op_instr});
    end
    if (illegal) begin
      illegal_cnt++;
      sb_event(20'h0);
    end
    if (timeout) timeout_cnt++;
  end

  initial begin
    vecs[0] = '{16'h0123, K_ALU,  0};
    vecs[1] = '{16'h6FFF, K_ALU,  1};
    vecs[2] = '{16'h7000, K_MOVE, 2};
    vecs[3] = '{16'h8ABC, K_ALUI, 0};
    vecs[4] = '{16'h9001, K_ALUI, 1};
    vecs[5] = '{16'hA000, K_ILL,  0};
    vecs[6] = '{16'hE777, K_ILL,  0};
    vecs[7] = '{16'hF0F0, K_MOVI, 2};
    vecs[8] = '{16'hB000, K_ILL,  0};

    enable = 1'b0;
    bus.in_instr = '0;
    do_reset();

    // reset state
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_op_instr", 32'(bus.op_instr), 32'd0);
    check("rst_starts", 32'({bus.start_move, bus.start_movi, bus.start_ALU, bus.start_ALUI}), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);

    // single dispatch with latency and hold checks
    enable = 1'b1;
    push_exp(16'h7ABC, K_MOVE);
    check("lat_start_n", 32'(bus.start_move), 32'd0);
    tick();
    check("lat_start_n1", 32'(bus.start_move), 32'd0);
    tick();
    check("lat_start_n2", 32'(bus.start_move), 32'd1);
    check("single_op_instr", 32'(bus.op_instr), 32'h7ABC);
    tick();
    check("single_start_one_cycle", 32'(bus.start_move), 32'd0);
    tick();
    check("single_op_hold", 32'(bus.op_instr), 32'h7ABC);
    check("single_busy_wait", 32'(busy), 32'd1);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    check("single_state_idle", 32'(dbg_state), 32'd0);
    check("single_busy_clear", 32'(busy), 32'd0);

    // opcode table
    for (int i = 0; i < 9; i++) begin
      push_exp(vecs[i].instr, vecs[i].kind);
      if (vecs[i].kind != K_ILL) serve(1, vecs[i].delay);
      else repeat (3) tick();
      tick();
      check("tbl_busy", 32'(busy), 32'd0);
      check("tbl_count", 32'(count), 32'd0);
    end

    // full FIFO, then drain in order
    do_reset();
    enable = 1'b0;
    push_exp(16'h0001, K_ALU);
    push_exp(16'h1002, K_ALU);
    push_exp(16'h8003, K_ALUI);
    push_exp(16'h9004, K_ALUI);
    check("full_count", 32'(count), 32'd4);
    check("full_in_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_instr = 16'hF005;
    tick();
    bus.in_valid = 1'b0;
    check("full_refused", 32'(count), 32'd4);
    enable = 1'b1;
    serve(4, 0);
    tick();
    check("full_drained", 32'(count), 32'd0);
    check("full_busy", 32'(busy), 32'd0);

    // illegal head discarded, next entry issues
    do_reset();
    enable = 1'b0;
    push_exp(16'hA123, K_ILL);
    push_exp(16'h2001, K_ALU);
    enable = 1'b1;
    serve(1, 0);
    check("ill_op_instr", 32'(bus.op_instr), 32'h2001);

    // timeout after TIMEOUT WAIT edges
    do_reset();
    enable = 1'b1;
    push_exp(16'hF0FF, K_MOVI);
    wait_start();
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("to_early", 32'(timeout), 32'd0);
    end
    tick();
    check("to_pulse", 32'(timeout), 32'd1);
    check("to_state_idle", 32'(dbg_state), 32'd0);
    tick();
    check("to_one_cycle", 32'(timeout), 32'd0);
    check("to_count", 32'(timeout_cnt), 32'd1);

    // reset during WAIT with two entries queued
    do_reset();
    enable = 1'b1;
    push_exp(16'h0011, K_ALU);
    wait_start();
    push(16'h3333);
    push(16'h7444);
    check("rw_count_before", 32'(count), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rw_count", 32'(count), 32'd0);
    check("rw_busy", 32'(busy), 32'd0);
    check("rw_no_timeout", 32'(timeout), 32'd0);
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    repeat (8) tick();
    check("rw_state_idle", 32'(dbg_state), 32'd0);
    check("rw_busy_after", 32'(busy), 32'd0);

    // enable dropped during WAIT
    do_reset();
    enable = 1'b1;
    push_exp(16'h3033, K_ALU);
    wait_start();
    push_exp(16'h7077, K_MOVE);
    enable = 1'b0;
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    check("en_back_idle", 32'(dbg_state), 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("en_held_count", 32'(count), 32'd1);
      check("en_held_state", 32'(dbg_state), 32'd0);
    end
    enable = 1'b1;
    serve(1, 0);
    tick();
    check("en_drained", 32'(count), 32'd0);

    repeat (3) tick();
    check("sb_queue_empty", 32'(exp_q.size()), 32'd0);
    check("illegal_total", 32'(illegal_cnt), 32'd4);
    check("timeout_total", 32'(timeout_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
